outlier_streamer: RTL and testbench

OUTLIER_STREAMER -- requirements
Module: outlier_streamer

---
 rtl/outlier_streamer.sv | 172 +++++++++++++++++
 tb/tb_outlier_streamer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/outlier_streamer.sv
// outlier_streamer: drains the upstream outlier FIFO through a 2-entry skid
// buffer onto an AXI-Stream master, holding one word back until termination
// is known so the final beat can carry tlast.
// Optional feature: define OUTLIER_STREAMER_TRAILER_EN to end the stream with
// a trailer beat carrying the outlier count instead of tlast on the last word.
module outlier_streamer #(
    parameter int unsigned N = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   fifo_dout,
    input  logic           fifo_empty,
    output logic           fifo_rd_en,
    input  logic           ctrl_done,
    output logic [N-1:0]   m_axis_tdata,
    output logic           m_axis_tvalid,
    input  logic           m_axis_tready,
    output logic           m_axis_tlast,
    output logic [2*N-1:0] outlier_count,
    output logic           finished
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LAST  = 2'd1,
`ifdef OUTLIER_STREAMER_TRAILER_EN
        TRAIL = 2'd2,
`endif
        FIN   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   buf0_q, buf0_d;
    logic [N-1:0]   buf1_q, buf1_d;
    logic [1:0]     occ_q, occ_d;
    logic           in_flight_q, in_flight_d;
    logic           done_q1_q, done_q1_d;
    logic           done_q2_q, done_q2_d;
    logic           armed_q, armed_d;
    logic [2*N-1:0] count_q, count_d;

    logic [1:0]     pending;
    logic           beat_is_data;
    logic           pop;

    assign pending       = occ_q + {1'b0, in_flight_q};
    assign pop           = m_axis_tvalid && m_axis_tready && beat_is_data;
    assign outlier_count = count_q;
    assign finished      = (state_q == FIN);

    // Next state, stream outputs and FIFO read request (all from registered state)
    always_comb begin
        state_d       = state_q;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        beat_is_data  = 1'b0;
        fifo_rd_en    = 1'b0;
        case (state_q)
            RUN: begin
                if (occ_q != 2'd0 && (occ_q == 2'd2 || in_flight_q)) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = buf0_q;
                    beat_is_data  = 1'b1;
                end
                if (!reset && armed_q && !fifo_empty && pending < 2'd2) begin
                    fifo_rd_en = 1'b1;
                end
                if (done_q2_q && fifo_empty && !in_flight_q) begin
                    state_d = LAST;
                end
            end
            LAST: begin
`ifdef OUTLIER_STREAMER_TRAILER_EN
                if (occ_q != 2'd0) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = buf0_q;
                    beat_is_data  = 1'b1;
                end else begin
                    state_d = TRAIL;
                end
`else
                if (occ_q != 2'd0) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = buf0_q;
                    m_axis_tlast  = (occ_q == 2'd1);
                    beat_is_data  = 1'b1;
                    if (m_axis_tready && occ_q == 2'd1) begin
                        state_d = FIN;
                    end
                end else begin
                    // Nothing was ever buffered: close the stream with a sentinel
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = '1;
                    m_axis_tlast  = 1'b1;
                    if (m_axis_tready) begin
                        state_d = FIN;
                    end
                end
`endif
            end
`ifdef OUTLIER_STREAMER_TRAILER_EN
            TRAIL: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = count_q[N-1:0];
                m_axis_tlast  = 1'b1;
                if (m_axis_tready) begin
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Skid buffer update: a pop shifts first, then a returning word fills the first free slot
    always_comb begin
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        occ_d       = occ_q;
        if (pop) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end
        if (in_flight_q) begin
            if (occ_d == 2'd0) begin
                buf0_d = fifo_dout;
            end else begin
                buf1_d = fifo_dout;
            end
            occ_d = occ_d + 2'd1;
        end
        in_flight_d = fifo_rd_en;
        done_q1_d   = done_q1_q | ctrl_done;
        done_q2_d   = done_q1_q;
        armed_d     = 1'b1;
        count_d     = count_q;
        if (pop && count_q != '1) begin
            count_d = count_q + (2*N)'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            buf0_q      <= '0;
            buf1_q      <= '0;
            occ_q       <= '0;
            in_flight_q <= 1'b0;
            done_q1_q   <= 1'b0;
            done_q2_q   <= 1'b0;
            armed_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            occ_q       <= occ_d;
            in_flight_q <= in_flight_d;
            done_q1_q   <= done_q1_d;
            done_q2_q   <= done_q2_d;
            armed_q     <= armed_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_outlier_streamer.sv
// Bench for outlier_streamer: an upstream FIFO model feeds scenario words,
// expected beats are derived from the word list alone, and one compare
// process checks every cycle. Honors OUTLIER_STREAMER_TRAILER_EN.
module tb_outlier_streamer;
    localparam int unsigned N = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   fifo_dout = '0;
    logic           fifo_empty = 1'b1;
    logic           fifo_rd_en;
    logic           ctrl_done = 1'b0;
    logic [N-1:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b0;
    logic           m_axis_tlast;
    logic [2*N-1:0] outlier_count;
    logic           finished;

    outlier_streamer #(.N(N)) dut (
        .clock(clock), .reset(reset),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .ctrl_done(ctrl_done),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .outlier_count(outlier_count), .finished(finished)
    );

    always #5 clock = ~clock;

    // ---------------- driver-owned state ----------------
    logic [N-1:0]   fq[$];
    logic           rd_seen = 1'b0;
    logic [N-1:0]   scen_words[$];
    int unsigned    rdy_mode = 0;
    int unsigned    rdy_idx = 0;
    logic [3:0]     rdy_pat = 4'b1001;
    logic [N-1:0]   pin_d[$];
    logic           pin_l[$];
    logic [2*N-1:0] pin_cnt = '0;
    logic           pin_en = 1'b0;
    logic           timeout_req = 1'b0;

    // ---------------- compare-owned state ----------------
    typedef struct {
        logic [N-1:0] d;
        logic         l;
        logic         is_data;
    } beat_t;
    beat_t          exp_q[$];
    beat_t          e;
    logic [N-1:0]   log_d[$];
    logic           log_l[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [2*N-1:0] mcount = '0;
    logic           mfin = 1'b0;
    int             outstanding = 0;
    logic           prev_stall = 1'b0;
    logic [N-1:0]   prev_d = '0;
    logic           prev_l = 1'b0;
    int             since_rst = 0;
    logic           acc, acc_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Compare process: sampled mid-cycle, after the driver has set this cycle's inputs
    always @(negedge clock) begin
        #2;
        if (reset) begin
            chk("rd_en_during_reset", 64'(fifo_rd_en), 64'd0);
            exp_q.delete();
`ifdef OUTLIER_STREAMER_TRAILER_EN
            foreach (scen_words[i]) begin
                e.d = scen_words[i]; e.l = 1'b0; e.is_data = 1'b1;
                exp_q.push_back(e);
            end
            e.d = N'(scen_words.size()); e.l = 1'b1; e.is_data = 1'b0;
            exp_q.push_back(e);
`else
            if (scen_words.size() == 0) begin
                e.d = {N{1'b1}}; e.l = 1'b1; e.is_data = 1'b0;
                exp_q.push_back(e);
            end else begin
                foreach (scen_words[i]) begin
                    e.d = scen_words[i]; e.l = (i == scen_words.size() - 1); e.is_data = 1'b1;
                    exp_q.push_back(e);
                end
            end
`endif
            log_d.delete(); log_l.delete();
            mcount = '0; mfin = 1'b0; outstanding = 0; prev_stall = 1'b0; since_rst = 0;
        end else begin
            if (since_rst < 100) since_rst++;
            if (since_rst == 1) begin
                chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
                chk("reset_tlast", 64'(m_axis_tlast), 64'd0);
                chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
                chk("reset_count", 64'(outlier_count), 64'd0);
                chk("reset_finished", 64'(finished), 64'd0);
                chk("rd_en_after_reset", 64'(fifo_rd_en), 64'd0);
            end else begin
                chk("outlier_count", 64'(outlier_count), 64'(mcount));
                chk("finished", 64'(finished), 64'(mfin));
            end
            if (prev_stall) begin
                chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_tdata", 64'(m_axis_tdata), 64'(prev_d));
                chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_l));
            end
            if (mfin) begin
                chk("tvalid_after_fin", 64'(m_axis_tvalid), 64'd0);
                chk("rd_en_after_fin", 64'(fifo_rd_en), 64'd0);
            end
            acc = m_axis_tvalid && m_axis_tready;
            acc_data = 1'b0;
            if (acc && !mfin) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat_tvalid", 64'(m_axis_tvalid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_tdata", 64'(m_axis_tdata), 64'(e.d));
                    chk("beat_tlast", 64'(m_axis_tlast), 64'(e.l));
                    log_d.push_back(m_axis_tdata);
                    log_l.push_back(m_axis_tlast);
                    acc_data = e.is_data;
                    if (acc_data && mcount != '1) mcount = mcount + 1;
                    if (e.l) begin
                        mfin = 1'b1;
                        if (pin_en) begin
                            chk("pin_beat_count", 64'(log_d.size()), 64'(pin_d.size()));
                            chk("pin_outlier_count", 64'(mcount), 64'(pin_cnt));
                            foreach (pin_d[i]) begin
                                if (i < log_d.size()) begin
                                    chk("pin_tdata", 64'(log_d[i]), 64'(pin_d[i]));
                                    chk("pin_tlast", 64'(log_l[i]), 64'(pin_l[i]));
                                end
                            end
                        end
                    end
                end
            end
            outstanding = outstanding + int'(fifo_rd_en) - int'(acc_data);
            if (fifo_rd_en) chk("occupancy_bound", 64'(outstanding <= 2), 64'd1);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
            if (timeout_req) chk("scenario_timeout_finished", 64'(finished), 64'd1);
        end
    end

    // One clock of stimulus: FIFO return, pushes, control inputs, ready pattern
    task automatic cycle(input logic rst, input logic done, input logic push_en, input logic [N-1:0] w);
        @(negedge clock);
        if (rd_seen && fq.size() != 0) fifo_dout = fq.pop_front();
        reset = rst;
        ctrl_done = done;
        if (rst) fq.delete();
        else if (push_en) fq.push_back(w);
        fifo_empty = (fq.size() == 0);
        if (rst) m_axis_tready = 1'b0;
        else begin
            case (rdy_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = rdy_pat[rdy_idx % 4];
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            rdy_idx++;
        end
        #1;
        rd_seen = fifo_rd_en;
    endtask

    // dmode 0: done with last push; 1: done later; 2: done with last push then dropped
    task automatic run(input int unsigned dmode, input int unsigned max_gap);
        logic dl;
        dl = 1'b0;
        rdy_idx = 0;
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        foreach (scen_words[i]) begin
            repeat ($urandom_range(0, max_gap)) cycle(1'b0, dl, 1'b0, '0);
            if (i == scen_words.size() - 1 && dmode != 1) dl = 1'b1;
            cycle(1'b0, dl, 1'b1, scen_words[i]);
        end
        if (scen_words.size() == 0 || dmode == 1) begin
            repeat (3) cycle(1'b0, dl, 1'b0, '0);
            dl = 1'b1;
        end
        for (int c = 0; c < 300 && !mfin; c++)
            cycle(1'b0, (dmode == 2 && c >= 3) ? 1'b0 : dl, 1'b0, '0);
        if (!mfin) begin
            timeout_req = 1'b1;
            cycle(1'b0, 1'b0, 1'b0, '0);
            timeout_req = 1'b0;
        end
        repeat (4) cycle(1'b0, (dmode == 2) ? 1'b0 : 1'b1, 1'b0, '0);
    endtask

    initial begin
        // Three words, ready always high, done rises with the last push
        scen_words = {16'd5, 16'd9, 16'd12};
`ifdef OUTLIER_STREAMER_TRAILER_EN
        pin_d = {16'd5, 16'd9, 16'd12, 16'd3}; pin_l = {1'b0, 1'b0, 1'b0, 1'b1};
`else
        pin_d = {16'd5, 16'd9, 16'd12}; pin_l = {1'b0, 1'b0, 1'b1};
`endif
        pin_cnt = 32'd3; pin_en = 1'b1; rdy_mode = 0;
        run(0, 0);

        // Empty stream
        scen_words.delete();
`ifdef OUTLIER_STREAMER_TRAILER_EN
        pin_d = {16'h0000}; pin_l = {1'b1};
`else
        pin_d = {16'hFFFF}; pin_l = {1'b1};
`endif
        pin_cnt = 32'd0; rdy_mode = 0;
        run(1, 0);

        // Ready toggling 1,0,0,1
        scen_words = {16'd3, 16'd7, 16'd8, 16'd20};
`ifdef OUTLIER_STREAMER_TRAILER_EN
        pin_d = {16'd3, 16'd7, 16'd8, 16'd20, 16'd4}; pin_l = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        pin_d = {16'd3, 16'd7, 16'd8, 16'd20}; pin_l = {1'b0, 1'b0, 1'b0, 1'b1};
`endif
        pin_cnt = 32'd4; rdy_mode = 1;
        run(0, 0);

        // Two words
        scen_words = {16'd4, 16'd6};
`ifdef OUTLIER_STREAMER_TRAILER_EN
        pin_d = {16'd4, 16'd6, 16'd2}; pin_l = {1'b0, 1'b0, 1'b1};
`else
        pin_d = {16'd4, 16'd6}; pin_l = {1'b0, 1'b1};
`endif
        pin_cnt = 32'd2; rdy_mode = 0;
        run(2, 1);
        pin_en = 1'b0;

        // Reset after two of four words have been accepted
        scen_words = {16'd10, 16'd11, 16'd12, 16'd13};
        rdy_mode = 0; rdy_idx = 0;
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        foreach (scen_words[i]) cycle(1'b0, 1'b0, 1'b1, scen_words[i]);
        for (int c = 0; c < 100 && log_d.size() < 2; c++) cycle(1'b0, 1'b0, 1'b0, '0);
        if (log_d.size() < 2) begin
            timeout_req = 1'b1;
            cycle(1'b0, 1'b0, 1'b0, '0);
            timeout_req = 1'b0;
        end
        scen_words.delete();
        cycle(1'b1, 1'b0, 1'b0, '0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, '0);

        // Randomized scenarios
        for (int s = 0; s < 25; s++) begin
            scen_words.delete();
            for (int k = 0; k < int'($urandom_range(0, 8)); k++) scen_words.push_back(N'($urandom));
            rdy_mode = $urandom_range(0, 2);
            run($urandom_range(0, 2), $urandom_range(0, 2));
        end

        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
